ysyx_23060191_ifu: RTL and testbench
====================================

# ysyx_23060191_ifu

Instruction fetch unit for the single-issue ysyx_23060191 core. It owns the PC register, issues one instruction-memory read at a time to the instruction memory, and holds each fetched instruction in a single-entry output register until the decode stage accepts it. It handles branch/jump redirects from execute at any point in the fetch cycle and discards stale memory responses.

## Interface
- WIDTH, 32: datapath width (CPU_WIDTH).
- RESET_PC, 32'h8000_0000: PC loaded on reset.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  WIDTH  target PC, used as-is with no alignment masking.
- imem_req  out  1  read request; memory always accepts it in the cycle it is high.
- imem_addr  out  WIDTH  read address; equals pc register.
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after the accepted request.
- imem_rdata  in  WIDTH  instruction word, valid with imem_rvalid.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts; a transfer happens when inst_valid && inst_ready.
- inst  out  WIDTH  fetched instruction.
- inst_pc  out  WIDTH  PC of inst.

## Operation
- Registers: pc, state {REQ, WAIT, HOLD}, drop flag, inst, inst_pc, inst_valid.
- Reset values: pc=RESET_PC, state=REQ, drop=0, inst_valid=0, inst=0, inst_pc=0.
- imem_req = (state==REQ) && !rst; imem_addr = pc. The value is combinational from registers.
- REQ: issue the request, then go to WAIT.
- WAIT, imem_rvalid=1 and drop=0:
  - inst<=imem_rdata, inst_pc<=pc, inst_valid<=1.
  - Go to HOLD.
- WAIT, imem_rvalid=1 and drop=1: discard the data, drop<=0, go to REQ. pc already holds the redirect target.
- WAIT, imem_rvalid=0: remain in WAIT.
- HOLD, inst_ready=1: inst_valid<=0, pc<=pc+4, go to REQ.
- HOLD, inst_ready=0: hold inst, inst_pc and inst_valid stable.
- Redirect (redirect_valid=1) has priority over every rule above. In all cases pc<=redirect_pc. Per state:
  - REQ: the request still issues this cycle. Then drop<=1 and go to WAIT.
  - WAIT without rvalid: drop<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: discard the response, drop<=0, go to REQ.
  - HOLD: inst_valid<=0, go to REQ. If inst_ready is also high, the transfer still completes this cycle, but pc takes redirect_pc and not pc+4.
- pc+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC → 32'h0000_0000).
- imem_rvalid in REQ or HOLD is ignored and has no state effect.
- At most one request is outstanding. The memory must not return more than one response per request.
- rst in any state, including WAIT with a request in flight, restores the reset values next edge. A response arriving after reset release, before the first new request, falls in REQ and is ignored.

## Timing
- With 1-cycle memory latency, there are 3 cycles per instruction when decode is always ready:
  - cycle n: REQ
  - cycle n+1: WAIT, rvalid
  - cycle n+2: HOLD, inst_valid=1, accepted
  - cycle n+3: next REQ
- Fetch-to-valid latency: inst_valid rises the cycle after imem_rvalid is sampled.
- Redirect-to-request latency: the request to redirect_pc issues 1 cycle after redirect. The exception is a redirect in REQ or in WAIT without rvalid; there the request waits for the stale response, then follows 1 cycle later.
- The first imem_req (addr=RESET_PC) is high in the first cycle rst is low.
- inst_valid never drops without a transfer, except on redirect or rst.

## Test plan
- Reset then straight-line fetch, 1-cycle memory, inst_ready=1:
  - imem_addr sequence is 8000_0000, 8000_0004, 8000_0008.
  - inst_pc/inst pairs match the memory contents.
  - One inst_valid pulse every 3 cycles.
- Backpressure: hold inst_ready=0 for 5 cycles in HOLD.
  - inst and inst_pc stay stable; imem_req=0 throughout.
  - pc advances by 4 only after ready.
- Redirect while WAIT with a 3-cycle-latency memory: redirect_pc=8000_0100 in the cycle after the request to 8000_0004.
  - The stale response is discarded, with no inst_valid.
  - The next imem_addr is 8000_0100.
- Redirect in HOLD coinciding with inst_ready=1:
  - The held instruction is transferred once.
  - The next request address is redirect_pc, not pc+4.
- Simultaneous redirect and imem_rvalid in WAIT:
  - Data is discarded.
  - The request to redirect_pc appears the next cycle.
- rst asserted mid-WAIT, then the late rvalid arrives after release:
  - Outputs return to reset values.
  - The response is ignored.
  - Fetch restarts at 8000_0000.
- Wrap: redirect to FFFF_FFFC, accept → next imem_addr is 0000_0000.

Source files
------------

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: owns the PC, keeps one instruction-memory read in
// flight, and parks each fetched word in a single-entry register until decode
// takes it. Redirects from execute win over everything else; a response that
// belongs to a PC abandoned by a redirect is marked stale and thrown away.
module ysyx_23060191_ifu #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             drop_q;
  logic [WIDTH-1:0] inst_q;
  logic [WIDTH-1:0] inst_pc_q;
  logic             inst_valid_q;
  logic [WIDTH-1:0] pc_inc_d;

  // Sequential PC; the add wraps naturally at 2^WIDTH.
  assign pc_inc_d = pc_q + WIDTH'(4);

  // Request is a pure function of state so memory sees it early in the cycle;
  // gated by rst so nothing issues while reset is held.
  assign imem_req   = (state_q == S_REQ) && !rst;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  // Fetch FSM: request -> wait for response -> hold for decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          // The request has already gone out; a redirect here only makes
          // its eventual response stale.
          state_q <= S_WAIT;
          if (redirect_valid) begin
            pc_q   <= redirect_pc;
            drop_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect_valid || drop_q) begin
              // Response is for an abandoned PC; refetch from pc_q.
              drop_q  <= 1'b0;
              state_q <= S_REQ;
              if (redirect_valid) pc_q <= redirect_pc;
            end else begin
              inst_q       <= imem_rdata;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // Still waiting on the old response; remember to discard it.
            pc_q   <= redirect_pc;
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            // A concurrent handshake still completes on the bus; only the
            // follow-on PC changes.
            pc_q         <= redirect_pc;
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end else if (inst_ready) begin
            pc_q         <= pc_inc_d;
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Bench for the fetch unit: a latency-programmable memory, a program-order
// reference (which PC must be requested/delivered next), directed scenarios
// with cycle-exact expectations, then a randomized run.
module tb_ysyx_23060191_ifu;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, redirect_valid = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;

  always #5 clk = ~clk;

  ysyx_23060191_ifu #(.WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0F0F) * 32'h0001_0003) + 32'h1;
  endfunction

  // stimulus controls for the next cycle
  logic        rst_c = 1'b1, redir_c = 1'b0, ready_c = 1'b0, force_rv = 1'b0;
  logic [31:0] rpc_c = '0;
  int          lat_lo = 1, lat_hi = 1;

  // memory model
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  // reference: PC the next request/delivery must carry
  logic [31:0] nxt = RPC;
  bit          ph = 0;
  logic [31:0] ph_inst = '0, ph_ipc = '0;

  typedef struct { logic [31:0] a; logic [31:0] d; int c; } ev_t;
  ev_t req_q[$];
  ev_t xfer_q[$];
  int  cyc = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_ipc;

  task automatic cycle();
    logic rv;
    logic [31:0] rd;
    @(negedge clk);
    rv = 1'b0; rd = '0;
    if (pend) begin
      if (cnt == 0) begin rv = 1'b1; rd = memf(paddr); pend = 0; end
      else cnt--;
    end
    if (rst_c) begin pend = 0; rv = 1'b0; end
    if (force_rv) begin rv = 1'b1; rd = 32'hDEAD_BEEF; end
    rst = rst_c; redirect_valid = redir_c; redirect_pc = rpc_c;
    inst_ready = ready_c; imem_rvalid = rv; imem_rdata = rd;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_inst = inst; s_ipc = inst_pc;
    if (!rst_c) begin
      if (ph) begin
        check("hold_v", 64'(s_valid), 64'(1'b1));
        check("hold_inst", 64'(s_inst), 64'(ph_inst));
        check("hold_pc", 64'(s_ipc), 64'(ph_ipc));
      end
      if (s_req) begin
        check("req_addr", 64'(s_addr), 64'(nxt));
        check("outstanding", 64'(pend), 64'(1'b0));
        req_q.push_back('{s_addr, 32'h0, cyc});
        pend = 1; paddr = s_addr;
        cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
      end
      if (s_valid && ready_c) begin
        check("xfer_pc", 64'(s_ipc), 64'(nxt));
        check("xfer_inst", 64'(s_inst), 64'(memf(s_ipc)));
        xfer_q.push_back('{s_ipc, s_inst, cyc});
      end
      ph = s_valid && !ready_c && !redir_c;
      ph_inst = s_inst; ph_ipc = s_ipc;
      if (s_valid && ready_c) nxt = s_ipc + 32'd4;
      if (redir_c) nxt = rpc_c;
    end else begin
      nxt = RPC; ph = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_c = 1'b1; redir_c = 1'b0; force_rv = 1'b0;
    cycle(); cycle();
    rst_c = 1'b0;
  endtask

  task automatic run_until_req(input string tag);
    bit f = 0;
    for (int i = 0; i < 20 && !f; i++) begin cycle(); f = s_req; end
    check(tag, 64'(f), 64'(1'b1));
  endtask

  task automatic run_until_valid(input string tag);
    bit f = 0;
    for (int i = 0; i < 20 && !f; i++) begin cycle(); f = s_valid; end
    check(tag, 64'(f), 64'(1'b1));
  endtask

  initial begin
    int c0, r, t, viol, nx, last_prog, nxfers;
    bit f, stalled;
    logic [31:0] hp, hi;

    // ---- reset and straight-line fetch, 1-cycle memory ----
    ready_c = 1'b1; lat_lo = 1; lat_hi = 1;
    do_reset();
    check("rst_valid", 64'(s_valid), 64'(1'b0));
    check("rst_inst", 64'(s_inst), 64'(32'h0));
    check("rst_ipc", 64'(s_ipc), 64'(32'h0));
    check("rst_req", 64'(s_req), 64'(1'b0));
    check("rst_addr", 64'(s_addr), 64'(RPC));
    req_q.delete(); xfer_q.delete();
    c0 = cyc;
    repeat (9) cycle();
    check("sl_nreq", 64'(req_q.size()), 64'(3));
    check("sl_nxfer", 64'(xfer_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < req_q.size(); i++) begin
      check("sl_req_addr", 64'(req_q[i].a), 64'(RPC + 32'(4 * i)));
      check("sl_req_cyc", 64'(req_q[i].c), 64'(c0 + 3 * i));
    end
    for (int i = 0; i < 3 && i < xfer_q.size(); i++) begin
      check("sl_xfer_pc", 64'(xfer_q[i].a), 64'(RPC + 32'(4 * i)));
      check("sl_xfer_cyc", 64'(xfer_q[i].c), 64'(c0 + 2 + 3 * i));
    end

    // ---- backpressure: decode stalls for 5 cycles ----
    ready_c = 1'b0;
    run_until_valid("bp_to");
    hp = s_ipc; hi = s_inst; viol = 0;
    repeat (5) begin
      cycle();
      if (!s_valid || s_ipc != hp || s_inst != hi || s_req || s_addr != hp) viol++;
    end
    check("bp_stable", 64'(viol), 64'(0));
    ready_c = 1'b1; req_q.delete(); xfer_q.delete();
    cycle(); cycle();
    check("bp_xfer_n", 64'(xfer_q.size()), 64'(1));
    check("bp_nreq", 64'(req_q.size()), 64'(1));
    if (req_q.size() > 0) check("bp_next_addr", 64'(req_q[0].a), 64'(hp + 32'd4));

    // ---- redirect in WAIT, 3-cycle memory ----
    lat_lo = 3; lat_hi = 3; ready_c = 1'b1;
    do_reset();
    f = 0;
    for (int i = 0; i < 20 && !f; i++) begin cycle(); f = s_req && (s_addr == RPC + 32'd4); end
    check("rw_to", 64'(f), 64'(1'b1));
    r = cyc - 1;
    redir_c = 1'b1; rpc_c = 32'h8000_0100; req_q.delete(); xfer_q.delete();
    cycle();
    redir_c = 1'b0;
    repeat (8) cycle();
    check("rw_nreq", 64'(req_q.size() > 0), 64'(1'b1));
    if (req_q.size() > 0) begin
      check("rw_addr", 64'(req_q[0].a), 64'(32'h8000_0100));
      check("rw_req_cyc", 64'(req_q[0].c), 64'(r + 4));
    end
    check("rw_nxfer", 64'(xfer_q.size()), 64'(1));
    if (xfer_q.size() > 0) begin
      check("rw_xfer_pc", 64'(xfer_q[0].a), 64'(32'h8000_0100));
      check("rw_xfer_cyc", 64'(xfer_q[0].c), 64'(r + 8));
    end

    // ---- redirect in HOLD together with accept ----
    lat_lo = 1; lat_hi = 1; ready_c = 1'b0;
    run_until_valid("rh_to");
    hp = s_ipc;
    ready_c = 1'b1; redir_c = 1'b1; rpc_c = 32'h8000_0200;
    req_q.delete(); xfer_q.delete(); t = cyc;
    cycle();
    redir_c = 1'b0;
    repeat (4) cycle();
    nx = 0;
    foreach (xfer_q[i]) if (xfer_q[i].a == hp) nx++;
    check("rh_once", 64'(nx), 64'(1));
    if (xfer_q.size() > 0) check("rh_xfer_cyc", 64'(xfer_q[0].c), 64'(t));
    check("rh_nreq", 64'(req_q.size() > 0), 64'(1'b1));
    if (req_q.size() > 0) begin
      check("rh_addr", 64'(req_q[0].a), 64'(32'h8000_0200));
      check("rh_req_cyc", 64'(req_q[0].c), 64'(t + 1));
    end

    // ---- redirect coinciding with rvalid in WAIT ----
    lat_lo = 2; lat_hi = 2;
    run_until_req("rv_to");
    cycle();
    redir_c = 1'b1; rpc_c = 32'h8000_0300;
    req_q.delete(); xfer_q.delete(); t = cyc;
    cycle();
    redir_c = 1'b0;
    repeat (3) cycle();
    check("rv_nxfer", 64'(xfer_q.size()), 64'(0));
    check("rv_nreq", 64'(req_q.size() > 0), 64'(1'b1));
    if (req_q.size() > 0) begin
      check("rv_addr", 64'(req_q[0].a), 64'(32'h8000_0300));
      check("rv_req_cyc", 64'(req_q[0].c), 64'(t + 1));
    end

    // ---- reset mid-WAIT, late response lands in REQ ----
    lat_lo = 4; lat_hi = 4;
    run_until_req("mr_to");
    cycle();
    rst_c = 1'b1; cycle(); cycle();
    rst_c = 1'b0; force_rv = 1'b1; lat_lo = 1; lat_hi = 1;
    req_q.delete(); xfer_q.delete(); t = cyc;
    cycle();
    force_rv = 1'b0;
    check("mr_req", 64'(s_req), 64'(1'b1));
    check("mr_addr", 64'(s_addr), 64'(RPC));
    check("mr_valid", 64'(s_valid), 64'(1'b0));
    check("mr_inst", 64'(s_inst), 64'(32'h0));
    check("mr_ipc", 64'(s_ipc), 64'(32'h0));
    repeat (4) cycle();
    check("mr_nxfer", 64'(xfer_q.size() > 0), 64'(1'b1));
    if (xfer_q.size() > 0) begin
      check("mr_xfer_pc", 64'(xfer_q[0].a), 64'(RPC));
      check("mr_xfer_inst", 64'(xfer_q[0].d), 64'(memf(RPC)));
      check("mr_xfer_cyc", 64'(xfer_q[0].c), 64'(t + 2));
    end

    // ---- PC wrap ----
    run_until_req("wr_to");
    redir_c = 1'b1; rpc_c = 32'hFFFF_FFFC; req_q.delete(); xfer_q.delete();
    cycle();
    redir_c = 1'b0;
    repeat (6) cycle();
    check("wr_nreq", 64'(req_q.size() >= 2), 64'(1'b1));
    if (req_q.size() >= 2) begin
      check("wr_addr0", 64'(req_q[0].a), 64'(32'hFFFF_FFFC));
      check("wr_addr1", 64'(req_q[1].a), 64'(32'h0000_0000));
    end
    if (xfer_q.size() > 0) check("wr_xfer_pc", 64'(xfer_q[0].a), 64'(32'hFFFF_FFFC));

    // ---- randomized traffic ----
    lat_lo = 1; lat_hi = 4;
    last_prog = cyc; nxfers = 0; stalled = 0;
    for (int i = 0; i < 4000 && !stalled; i++) begin
      rst_c   = ($urandom_range(0, 299) == 0);
      ready_c = ($urandom_range(0, 3) != 0);
      redir_c = !rst_c && ($urandom_range(0, 19) == 0);
      rpc_c   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : $urandom;
      req_q.delete(); xfer_q.delete();
      cycle();
      if (s_req || xfer_q.size() > 0 || rst_c) last_prog = cyc;
      nxfers += xfer_q.size();
      if (cyc - last_prog > 50) stalled = 1;
    end
    rst_c = 1'b0; redir_c = 1'b0;
    check("rnd_stall", 64'(stalled), 64'(1'b0));
    check("rnd_progress", 64'(nxfers > 200), 64'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
